wb_commit_stage: RTL
====================

# wb_commit_stage

Parametrised writeback/commit stage for the five-stage LoongArch pipeline.
- Accepts one instruction per cycle from MEM through a valid/allowin handshake and performs the register-file write.
- Resolves a full exception vector (including TLB and address-error classes) to a single ecode/esubcode with bad-address selection, and raises the exception/ertn flush.
- Supports CSR reads with a configurable multi-cycle latency and maintains a retired-instruction counter.

## Interface
- XLEN, 32, datapath width (pc, vaddr, rf data, csr values)
- RF_AW, 5, register-file address width
- CSR_RD_LAT, 0, extra cycles a CSR-reading instruction waits in WB before committing (0..7)
- INSTRET_W, 64, retired-instruction counter width
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ms2ws_valid  in  1  MEM holds a valid instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc, ms_vaddr  in  XLEN  instruction pc; memory virtual address
- ms_exc  in  16  exception vector; bit indices fixed in package
- ms_ertn  in  1  instruction is ertn
- ms_rf_we, ms_rf_waddr, ms_rf_wdata  in  1/RF_AW/XLEN  rf write request
- ms_csr_re, ms_csr_we  in  1  CSR read / write
- ms_csr_num  in  14  CSR number
- ms_csr_wmask, ms_csr_wvalue  in  XLEN  CSR write mask/value
- csr_rvalue  in  XLEN  CSR read data, valid combinationally for held csr_num
- csr_re, csr_we  out  1  CSR read/write strobes
- csr_num  out  14
- csr_wmask, csr_wvalue  out  XLEN
- wb_ex, ertn_flush  out  1  flush pulses
- wb_pc  out  XLEN
- wb_ecode  out  6
- wb_esubcode  out  9
- wb_badv_we  out  1  BADV must be written
- wb_badv  out  XLEN
- ws_rf_we, ws_rf_waddr, ws_rf_wdata  out  1/RF_AW/XLEN  rf write port, also the ID forwarding/interlock source
- ws_busy  out  1  valid CSR-read instruction still waiting (ID must stall dependents)
- instret  out  INSTRET_W  retired count
- debug_wb_pc, debug_wb_rf_we(4), debug_wb_rf_wnum, debug_wb_rf_wdata  out  trace port

## Operation
- Exception bits: 0 INT, 1 ADEF, 2 TLBR_F, 3 PIF, 4 PPI_F, 5 SYS, 6 BRK, 7 INE, 8 IPE, 9 ALE, 10 ADEM, 11 TLBR_M, 12 PIL, 13 PIS, 14 PME, 15 PPI_M.
- Exception priority is descending bit index order within the fixed group order INT > fetch(1-4) > decode(5-8) > mem(9-15); highest-priority bit wins.
- Ecode mapping:
  - INT→0x00, PIL→0x01, PIS→0x02, PIF→0x03, PME→0x04, PPI_*→0x07
  - ADEF→0x08/esub 0, ADEM→0x08/esub 1
  - ALE→0x09, SYS→0x0B, BRK→0x0C, INE→0x0D, IPE→0x0E, TLBR_*→0x3F
  - All other esubcodes are 0.
- wb_badv_we=1 for fetch-group winners (wb_badv=wb_pc) and for ALE/ADEM/TLBR_M/PIL/PIS/PME/PPI_M (wb_badv=vaddr). It is 0 otherwise.
- wb_ex = ws_valid & |exc. ertn_flush = ws_valid & ertn & ~|exc. Both fire in the first cycle the entry is valid; they do not wait for CSR latency.
- An excepting or ertn entry never writes the rf or CSR. csr_we = ws_valid & ready_go & csr_we_reg & ~wb_ex.
- ws_rf_wdata = csr_re ? csr_rvalue : registered wdata. ws_rf_we = ws_valid & ready_go & rf_we & ~wb_ex & ~ertn_flush. debug_wb_rf_we = {4{ws_rf_we}}.
- instret increments by 1 per retirement: (ws_valid & ready_go & ~wb_ex). ertn counts as a retirement. The counter wraps modulo 2^INSTRET_W.
- All outputs except csr/rf data are zero-gated by ws_valid.

## Timing
- Reset values: ws_valid=0, wait counter=0, instret=0, all payload registers 0. Consequently every strobe output is 0 and wb_pc=0.
- ready_go = ~csr_re_reg | (cnt == CSR_RD_LAT). cnt loads 0 on capture and increments while ready_go=0. ws_allowin = ~ws_valid | ready_go.
- ws_busy = ws_valid & ~ready_go.
- Capture occurs on ms2ws_valid & ws_allowin. Latency is 1 cycle, or 1+CSR_RD_LAT for CSR reads.
- When wb_ex | ertn_flush, the next-cycle ws_valid=0 regardless of ms2ws_valid; the incoming entry is dropped.
- Back-to-back entries sustain one per cycle when not stalled. With CSR_RD_LAT=0 the stage never stalls.
- Reset mid-stall clears valid and counter on the next edge.

## Structure
- Package wb_pkg holds the exception bit index constants, the ecode/esubcode constants, and the exception vector width (16).
- Sub-module wb_exc_prio is purely combinational: exc vector in → ecode, esubcode, badv_sel, badv_we out.

## Test plan
- Plain add writing r5=0x1234 at pc 0x1c000000 → ws_rf_we=1 one cycle after capture, debug_wb_rf_we=0xF, instret 0→1.
- CSR_RD_LAT=2, csrrd r4 of csr 0x5 with rvalue 0xABCD → ws_busy high 2 cycles, ws_allowin=0 during that window, then r4=0xABCD written on the third cycle, and the following instruction is captured next.
- ms_exc with bits ALE|SYS|INT set, pc 0x1c000010, vaddr 0x3 → wb_ecode=0x00 (INT wins), wb_badv_we=0. With ALE alone → ecode 0x09, badv=0x3, no rf write, instret unchanged.
- ADEM alone → ecode 0x08, esubcode 1. TLBR_F alone → ecode 0x3F, badv=pc.
- ertn with a valid entry arriving the same cycle → ertn_flush=1, next-cycle ws_valid=0, incoming entry dropped.
- resetn low during a CSR wait → all outputs 0 next cycle. instret at all-ones retiring one instruction → wraps to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the writeback/commit stage: exception vector layout,
// LoongArch ecode/esubcode values and the bad-address source selector.
package wb_pkg;

  localparam int unsigned EXC_W = 16;

  // Exception vector bit positions.
  localparam int unsigned EXC_INT    = 0;
  localparam int unsigned EXC_ADEF   = 1;
  localparam int unsigned EXC_TLBR_F = 2;
  localparam int unsigned EXC_PIF    = 3;
  localparam int unsigned EXC_PPI_F  = 4;
  localparam int unsigned EXC_SYS    = 5;
  localparam int unsigned EXC_BRK    = 6;
  localparam int unsigned EXC_INE    = 7;
  localparam int unsigned EXC_IPE    = 8;
  localparam int unsigned EXC_ALE    = 9;
  localparam int unsigned EXC_ADEM   = 10;
  localparam int unsigned EXC_TLBR_M = 11;
  localparam int unsigned EXC_PIL    = 12;
  localparam int unsigned EXC_PIS    = 13;
  localparam int unsigned EXC_PME    = 14;
  localparam int unsigned EXC_PPI_M  = 15;

  // Architectural exception codes.
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [8:0] ESUB_ADEF = 9'd0;
  localparam logic [8:0] ESUB_ADEM = 9'd1;

  // Which captured address feeds BADV.
  typedef enum logic {
    BADV_PC    = 1'b0,
    BADV_VADDR = 1'b1
  } badv_sel_e;

endpackage

// File: rtl/wb_commit_stage_if.sv
// MEM -> WB pipeline bus: valid/allowin handshake plus the instruction payload.
interface wb_commit_stage_if import wb_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) ();

  logic             ms2ws_valid;
  logic             ws_allowin;
  logic [XLEN-1:0]  ms_pc;
  logic [XLEN-1:0]  ms_vaddr;
  logic [EXC_W-1:0] ms_exc;
  logic             ms_ertn;
  logic             ms_rf_we;
  logic [RF_AW-1:0] ms_rf_waddr;
  logic [XLEN-1:0]  ms_rf_wdata;
  logic             ms_csr_re;
  logic             ms_csr_we;
  logic [13:0]      ms_csr_num;
  logic [XLEN-1:0]  ms_csr_wmask;
  logic [XLEN-1:0]  ms_csr_wvalue;

  modport master (
    output ms2ws_valid, ms_pc, ms_vaddr, ms_exc, ms_ertn,
           ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_csr_re, ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
    input  ws_allowin
  );

  modport slave (
    input  ms2ws_valid, ms_pc, ms_vaddr, ms_exc, ms_ertn,
           ms_rf_we, ms_rf_waddr, ms_rf_wdata,
           ms_csr_re, ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
    output ws_allowin
  );

endinterface

// File: rtl/wb_exc_prio.sv
// Combinational exception resolver: picks the winning exception from the
// vector and reports its ecode/esubcode and whether/where BADV is written.
// Group order is INT > fetch > decode > mem; inside a group the higher bit wins.
module wb_exc_prio import wb_pkg::*; (
  input  logic [EXC_W-1:0] exc,
  output logic [5:0]       ecode,
  output logic [8:0]       esubcode,
  output badv_sel_e        badv_sel,
  output logic             badv_we
);

  // Priority chain from highest to lowest; an empty vector yields all zeros.
  always_comb begin
    ecode    = '0;
    esubcode = '0;
    badv_sel = BADV_PC;
    badv_we  = 1'b0;
    if (exc[EXC_INT]) begin
      ecode = ECODE_INT;
    end else if (exc[EXC_PPI_F]) begin
      ecode = ECODE_PPI;  badv_we = 1'b1;
    end else if (exc[EXC_PIF]) begin
      ecode = ECODE_PIF;  badv_we = 1'b1;
    end else if (exc[EXC_TLBR_F]) begin
      ecode = ECODE_TLBR; badv_we = 1'b1;
    end else if (exc[EXC_ADEF]) begin
      ecode = ECODE_ADE;  esubcode = ESUB_ADEF; badv_we = 1'b1;
    end else if (exc[EXC_IPE]) begin
      ecode = ECODE_IPE;
    end else if (exc[EXC_INE]) begin
      ecode = ECODE_INE;
    end else if (exc[EXC_BRK]) begin
      ecode = ECODE_BRK;
    end else if (exc[EXC_SYS]) begin
      ecode = ECODE_SYS;
    end else if (exc[EXC_PPI_M]) begin
      ecode = ECODE_PPI;  badv_sel = BADV_VADDR; badv_we = 1'b1;
    end else if (exc[EXC_PME]) begin
      ecode = ECODE_PME;  badv_sel = BADV_VADDR; badv_we = 1'b1;
    end else if (exc[EXC_PIS]) begin
      ecode = ECODE_PIS;  badv_sel = BADV_VADDR; badv_we = 1'b1;
    end else if (exc[EXC_PIL]) begin
      ecode = ECODE_PIL;  badv_sel = BADV_VADDR; badv_we = 1'b1;
    end else if (exc[EXC_TLBR_M]) begin
      ecode = ECODE_TLBR; badv_sel = BADV_VADDR; badv_we = 1'b1;
    end else if (exc[EXC_ADEM]) begin
      ecode = ECODE_ADE;  esubcode = ESUB_ADEM; badv_sel = BADV_VADDR; badv_we = 1'b1;
    end else if (exc[EXC_ALE]) begin
      ecode = ECODE_ALE;  badv_sel = BADV_VADDR; badv_we = 1'b1;
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: holds one instruction from MEM, performs the rf and
// CSR writes, raises exception/ertn flushes, stalls CSR reads for a fixed
// latency and counts retired instructions.
module wb_commit_stage import wb_pkg::*; #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RF_AW      = 5,
  parameter int unsigned CSR_RD_LAT = 0,
  parameter int unsigned INSTRET_W  = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  wb_commit_stage_if.slave     ms,
  input  logic [XLEN-1:0]      csr_rvalue,
  output logic                 csr_re,
  output logic                 csr_we,
  output logic [13:0]          csr_num,
  output logic [XLEN-1:0]      csr_wmask,
  output logic [XLEN-1:0]      csr_wvalue,
  output logic                 wb_ex,
  output logic                 ertn_flush,
  output logic [XLEN-1:0]      wb_pc,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic                 wb_badv_we,
  output logic [XLEN-1:0]      wb_badv,
  output logic                 ws_rf_we,
  output logic [RF_AW-1:0]     ws_rf_waddr,
  output logic [XLEN-1:0]      ws_rf_wdata,
  output logic                 ws_busy,
  output logic [INSTRET_W-1:0] instret,
  output logic [XLEN-1:0]      debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [RF_AW-1:0]     debug_wb_rf_wnum,
  output logic [XLEN-1:0]      debug_wb_rf_wdata
);

  localparam int unsigned CNT_W = 3;

  logic                 ws_valid;
  logic [CNT_W-1:0]     cnt;
  logic [INSTRET_W-1:0] instret_r;

  logic [XLEN-1:0]      pc_r;
  logic [XLEN-1:0]      vaddr_r;
  logic [EXC_W-1:0]     exc_r;
  logic                 ertn_r;
  logic                 rf_we_r;
  logic [RF_AW-1:0]     rf_waddr_r;
  logic [XLEN-1:0]      rf_wdata_r;
  logic                 csr_re_r;
  logic                 csr_we_r;
  logic [13:0]          csr_num_r;
  logic [XLEN-1:0]      csr_wmask_r;
  logic [XLEN-1:0]      csr_wvalue_r;

  logic                 ready_go;
  logic                 allowin;
  logic                 capture;
  logic                 flush;
  logic                 retire;

  logic [5:0]           ecode_i;
  logic [8:0]           esubcode_i;
  badv_sel_e            badv_sel_i;
  logic                 badv_we_i;

  assign ready_go      = ~csr_re_r | (cnt == CNT_W'(CSR_RD_LAT));
  assign allowin       = ~ws_valid | ready_go;
  assign ms.ws_allowin = allowin;
  assign capture       = ms.ms2ws_valid & allowin;

  // Flushes fire immediately, even while a CSR read would still be waiting.
  assign wb_ex         = ws_valid & (|exc_r);
  assign ertn_flush    = ws_valid & ertn_r & ~(|exc_r);
  assign flush         = wb_ex | ertn_flush;
  assign retire        = ws_valid & ready_go & ~wb_ex;

  wb_exc_prio u_exc_prio (
    .exc      (exc_r),
    .ecode    (ecode_i),
    .esubcode (esubcode_i),
    .badv_sel (badv_sel_i),
    .badv_we  (badv_we_i)
  );

  // Stage occupancy; a flush empties the stage and drops any incoming entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
    end else if (flush) begin
      ws_valid <= 1'b0;
    end else if (allowin) begin
      ws_valid <= ms.ms2ws_valid;
    end
  end

  // CSR-read wait counter: restarts on capture, advances while stalled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (capture) begin
      cnt <= '0;
    end else if (ws_valid && !ready_go) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Instruction payload captured on each accepted handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r         <= '0;
      vaddr_r      <= '0;
      exc_r        <= '0;
      ertn_r       <= 1'b0;
      rf_we_r      <= 1'b0;
      rf_waddr_r   <= '0;
      rf_wdata_r   <= '0;
      csr_re_r     <= 1'b0;
      csr_we_r     <= 1'b0;
      csr_num_r    <= '0;
      csr_wmask_r  <= '0;
      csr_wvalue_r <= '0;
    end else if (capture) begin
      pc_r         <= ms.ms_pc;
      vaddr_r      <= ms.ms_vaddr;
      exc_r        <= ms.ms_exc;
      ertn_r       <= ms.ms_ertn;
      rf_we_r      <= ms.ms_rf_we;
      rf_waddr_r   <= ms.ms_rf_waddr;
      rf_wdata_r   <= ms.ms_rf_wdata;
      csr_re_r     <= ms.ms_csr_re;
      csr_we_r     <= ms.ms_csr_we;
      csr_num_r    <= ms.ms_csr_num;
      csr_wmask_r  <= ms.ms_csr_wmask;
      csr_wvalue_r <= ms.ms_csr_wvalue;
    end
  end

  // Retired-instruction counter; ertn counts, excepting entries do not.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      instret_r <= '0;
    end else if (retire) begin
      instret_r <= instret_r + INSTRET_W'(1);
    end
  end

  assign instret     = instret_r;
  assign ws_busy     = ws_valid & ~ready_go;

  assign wb_pc       = ws_valid ? pc_r : '0;
  assign wb_ecode    = ws_valid ? ecode_i : '0;
  assign wb_esubcode = ws_valid ? esubcode_i : '0;
  assign wb_badv_we  = ws_valid & badv_we_i;
  assign wb_badv     = (ws_valid && badv_we_i) ?
                       ((badv_sel_i == BADV_VADDR) ? vaddr_r : pc_r) : '0;

  assign csr_re      = ws_valid & csr_re_r;
  assign csr_we      = ws_valid & ready_go & csr_we_r & ~wb_ex & ~ertn_flush;
  assign csr_num     = ws_valid ? csr_num_r : '0;
  assign csr_wmask   = csr_wmask_r;
  assign csr_wvalue  = csr_wvalue_r;

  assign ws_rf_we    = ws_valid & ready_go & rf_we_r & ~wb_ex & ~ertn_flush;
  assign ws_rf_waddr = ws_valid ? rf_waddr_r : '0;
  assign ws_rf_wdata = csr_re ? csr_rvalue : rf_wdata_r;

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{ws_rf_we}};
  assign debug_wb_rf_wnum  = ws_rf_waddr;
  assign debug_wb_rf_wdata = ws_rf_wdata;

endmodule
